// File: rtl/reg_div_seq_if.sv
// Register-file and command bundle for reg_div_seq.
// The slave modport is the divide sequencer; master is the controller and register-file side.
interface reg_div_seq_if #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 4
);
  logic         start;
  logic [D-1:0] src_a;
  logic [D-1:0] src_b;
  logic [D-1:0] dst_q;
  logic [D-1:0] dst_r;
  logic         busy;
  logic         done;
  logic [D-1:0] src;
  logic [W-1:0] Read;
  logic         RegWrite;
  logic [D-1:0] writeSrc;
  logic [W-1:0] writeValue;
  logic         Writeov;

  modport master (
    output start, src_a, src_b, dst_q, dst_r, Read,
    input  busy, done, src, RegWrite, writeSrc, writeValue, Writeov
  );

  modport slave (
    input  start, src_a, src_b, dst_q, dst_r, Read,
    output busy, done, src, RegWrite, writeSrc, writeValue, Writeov
  );
endinterface

// File: rtl/reg_div_seq.sv
// Multi-cycle restoring unsigned divider that reads its operands from and writes its results to a
// register file. Optional macro REM_WRITE_EN adds the remainder write-back state.
module reg_div_seq #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 4
) (
  input logic         CLK,
  input logic         Reset,
  reg_div_seq_if.slave bus
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    StIdle, StRdA, StRdB, StDiv, StWrQ, StWrR, StDone
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   div_q, div_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W:0]     rem_sh;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ov_q, ov_d;
  logic [D-1:0]   src_a_q, src_b_q, dst_q_q;
`ifdef REM_WRITE_EN
  logic [D-1:0]   dst_r_q;
`else
  logic           unused_dst_r;
  assign unused_dst_r = ^bus.dst_r;
`endif

  assign bus.busy    = (state_q != StIdle);
  assign bus.Writeov = ov_q;

  always_comb begin
    state_d        = state_q;
    q_d            = q_q;
    div_d          = div_q;
    rem_d          = rem_q;
    cnt_d          = cnt_q;
    ov_d           = ov_q;
    bus.done       = 1'b0;
    bus.src        = '0;
    bus.RegWrite   = 1'b0;
    bus.writeSrc   = '0;
    bus.writeValue = '0;
    rem_sh         = {rem_q, q_q[W-1]};
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          ov_d    = 1'b0;
          state_d = StRdA;
        end
      end
      StRdA: begin
        bus.src = src_a_q;
        q_d     = bus.Read;
        state_d = StRdB;
      end
      StRdB: begin
        bus.src = src_b_q;
        div_d   = bus.Read;
        cnt_d   = '0;
        if (bus.Read == '0) begin
          ov_d    = 1'b1;
          q_d     = '1;
          rem_d   = q_q;
          state_d = StWrQ;
        end else begin
          rem_d   = '0;
          state_d = StDiv;
        end
      end
      StDiv: begin
        q_d = {q_q[W-2:0], 1'b0};
        // Partial remainder stays below the divisor, so W bits hold it between steps.
        if (rem_sh >= {1'b0, div_q}) begin
          rem_d  = W'(rem_sh - {1'b0, div_q});
          q_d[0] = 1'b1;
        end else begin
          rem_d  = rem_sh[W-1:0];
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) state_d = StWrQ;
      end
      StWrQ: begin
        bus.RegWrite   = 1'b1;
        bus.writeSrc   = dst_q_q;
        bus.writeValue = q_q;
`ifdef REM_WRITE_EN
        state_d        = StWrR;
`else
        state_d        = StDone;
`endif
      end
`ifdef REM_WRITE_EN
      StWrR: begin
        bus.RegWrite   = 1'b1;
        bus.writeSrc   = dst_r_q;
        bus.writeValue = rem_q;
        state_d        = StDone;
      end
`endif
      StDone: begin
        bus.done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= StIdle;
      q_q     <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q_q <= '0;
`ifdef REM_WRITE_EN
      dst_r_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      if (state_q == StIdle && bus.start) begin
        src_a_q <= bus.src_a;
        src_b_q <= bus.src_b;
        dst_q_q <= bus.dst_q;
`ifdef REM_WRITE_EN
        dst_r_q <= bus.dst_r;
`endif
      end
    end
  end

endmodule
